remote_comm: RTL and testbench

Host-side command link for the Knight robot. A 16-bit command is serialized as two UART frames, high byte first, toward the robot's receiver. Single response bytes coming back from the robot are deserialized and presented with a ready flag. The block sits between the test bench or host and the KnightsTour RX/TX pins, with `TX` → robot `RX` and robot `TX` → `RX`.

---
 rtl/remote_comm.sv | 228 ++++++++++++++++++++++
 tb/tb_remote_comm.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/remote_comm.sv
// remote_comm: host-side UART command link; 16-bit command sent as two 8N1 frames (high byte first), single response bytes received.
// Latency: TX start bit on the clock after snd_cmd is accepted, cmd_snt after 20*BAUD_DIV clocks; resp_rdy one clock after the stop-bit sample.
// Backpressure: snd_cmd is only accepted while the transmitter is idle and is ignored mid-command; received bytes are overwritten by later good frames.
//
// Ports:
//   clk, rst        - single clock, synchronous active-high reset
//   cmd, snd_cmd    - command word and transmit request (cmd latched on acceptance)
//   cmd_snt         - level, both bytes of the last accepted command have left TX
//   TX              - serial output, idles high
//   RX              - asynchronous serial input
//   resp, resp_rdy  - last good received byte and its fresh-data flag
module remote_comm #(
    parameter int BAUD_DIV = 2604
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cmd,
    input  logic        snd_cmd,
    output logic        cmd_snt,
    output logic        TX,
    input  logic        RX,
    output logic [7:0]  resp,
    output logic        resp_rdy
);

    localparam int CW = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'((BAUD_DIV / 2) - 1);
    localparam logic [3:0]    STOP_IDX  = 4'd9;

    // Frame bit index 0 is the start bit, 1..8 carry data LSB first, 9 is the stop bit.
    function automatic logic frame_bit(input logic [7:0] b, input logic [3:0] idx);
        logic [3:0] di;
        di = idx - 4'd1;
        if (idx == 4'd0)
            return 1'b0;
        else if (idx <= 4'd8)
            return b[di[2:0]];
        else
            return 1'b1;
    endfunction

    // ------------------------------------------------------------------
    // Transmitter. Command completion is folded into the LOW -> IDLE
    // transition, so no separate DONE state is needed.
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        TX_IDLE = 2'd0,
        TX_HIGH = 2'd1,
        TX_LOW  = 2'd2
    } tx_state_t;

    tx_state_t      tx_state_q, tx_state_d;
    logic [15:0]    tx_hold_q, tx_hold_d;
    logic [CW-1:0]  tx_baud_q, tx_baud_d;
    logic [3:0]     tx_bit_q, tx_bit_d;
    logic           tx_q, tx_d;
    logic           cmd_snt_q, cmd_snt_d;
    logic [7:0]     tx_byte;

    assign tx_byte = (tx_state_q == TX_HIGH) ? tx_hold_q[15:8] : tx_hold_q[7:0];

    always_comb begin
        tx_state_d = tx_state_q;
        tx_hold_d  = tx_hold_q;
        tx_baud_d  = tx_baud_q;
        tx_bit_d   = tx_bit_q;
        tx_d       = tx_q;
        cmd_snt_d  = cmd_snt_q;
        case (tx_state_q)
            TX_IDLE: begin
                tx_d = 1'b1;
                if (snd_cmd) begin
                    tx_hold_d  = cmd;
                    cmd_snt_d  = 1'b0;
                    tx_state_d = TX_HIGH;
                    tx_baud_d  = '0;
                    tx_bit_d   = 4'd0;
                    tx_d       = 1'b0;      // start bit of the high byte
                end
            end
            TX_HIGH, TX_LOW: begin
                if (tx_baud_q == BAUD_LAST) begin
                    tx_baud_d = '0;
                    if (tx_bit_q == STOP_IDX) begin
                        tx_bit_d = 4'd0;
                        if (tx_state_q == TX_HIGH) begin
                            // Low byte's start bit follows the stop bit with no idle gap.
                            tx_state_d = TX_LOW;
                            tx_d       = 1'b0;
                        end else begin
                            tx_state_d = TX_IDLE;
                            tx_d       = 1'b1;
                            cmd_snt_d  = 1'b1;
                        end
                    end else begin
                        tx_bit_d = tx_bit_q + 4'd1;
                        tx_d     = frame_bit(tx_byte, tx_bit_q + 4'd1);
                    end
                end else begin
                    tx_baud_d = tx_baud_q + 1'b1;
                end
            end
            default: begin
                tx_state_d = TX_IDLE;
                tx_d       = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    typedef enum logic {
        RX_IDLE = 1'b0,
        RX_BUSY = 1'b1
    } rx_state_t;

    logic           rx_s1_q, rx_s1_d;
    logic           rx_s2_q, rx_s2_d;
    logic           rx_s3_q, rx_s3_d;   // previous synchronized value, for edge detect
    rx_state_t      rx_state_q, rx_state_d;
    logic [CW-1:0]  rx_baud_q, rx_baud_d;
    logic [3:0]     rx_bit_q, rx_bit_d;
    logic [7:0]     rx_shift_q, rx_shift_d;
    logic [7:0]     resp_q, resp_d;
    logic           resp_rdy_q, resp_rdy_d;

    always_comb begin
        rx_s1_d    = RX;
        rx_s2_d    = rx_s1_q;
        rx_s3_d    = rx_s2_q;
        rx_state_d = rx_state_q;
        rx_baud_d  = rx_baud_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        resp_d     = resp_q;
        resp_rdy_d = resp_rdy_q;
        case (rx_state_q)
            RX_IDLE: begin
                if (rx_s3_q && !rx_s2_q) begin
                    rx_state_d = RX_BUSY;
                    rx_baud_d  = '0;
                    rx_bit_d   = 4'd0;
                end
            end
            RX_BUSY: begin
                if (rx_bit_q == 4'd0) begin
                    // Mid-start-bit check filters glitches; resp_rdy only drops once
                    // the start bit is confirmed, so a glitch leaves the outputs alone.
                    if (rx_baud_q == HALF_LAST) begin
                        rx_baud_d = '0;
                        if (rx_s2_q) begin
                            rx_state_d = RX_IDLE;
                        end else begin
                            rx_bit_d   = 4'd1;
                            resp_rdy_d = 1'b0;
                        end
                    end else begin
                        rx_baud_d = rx_baud_q + 1'b1;
                    end
                end else if (rx_baud_q == BAUD_LAST) begin
                    rx_baud_d = '0;
                    if (rx_bit_q == STOP_IDX) begin
                        // Return to idle right at the stop sample so back-to-back frames are caught.
                        rx_state_d = RX_IDLE;
                        rx_bit_d   = 4'd0;
                        if (rx_s2_q) begin
                            resp_d     = rx_shift_q;
                            resp_rdy_d = 1'b1;
                        end
                    end else begin
                        rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
                        rx_bit_d   = rx_bit_q + 4'd1;
                    end
                end else begin
                    rx_baud_d = rx_baud_q + 1'b1;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q <= TX_IDLE;
            tx_hold_q  <= '0;
            tx_baud_q  <= '0;
            tx_bit_q   <= '0;
            tx_q       <= 1'b1;
            cmd_snt_q  <= 1'b0;
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_s3_q    <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_baud_q  <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            resp_q     <= '0;
            resp_rdy_q <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_hold_q  <= tx_hold_d;
            tx_baud_q  <= tx_baud_d;
            tx_bit_q   <= tx_bit_d;
            tx_q       <= tx_d;
            cmd_snt_q  <= cmd_snt_d;
            rx_s1_q    <= rx_s1_d;
            rx_s2_q    <= rx_s2_d;
            rx_s3_q    <= rx_s3_d;
            rx_state_q <= rx_state_d;
            rx_baud_q  <= rx_baud_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            resp_q     <= resp_d;
            resp_rdy_q <= resp_rdy_d;
        end
    end

    assign TX       = tx_q;
    assign cmd_snt  = cmd_snt_q;
    assign resp     = resp_q;
    assign resp_rdy = resp_rdy_q;

endmodule

// File: tb/tb_remote_comm.sv
// tb_remote_comm: directed bench for remote_comm with BAUD_DIV=16.
// Inputs change and outputs are sampled 1 time unit after the rising edge.
// TX can be looped back into RX to exercise both directions together.
module tb_remote_comm;

    localparam int BD = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] cmd = 16'h0000;
    logic        snd_cmd = 1'b0;
    logic        cmd_snt;
    logic        tx_w;
    logic        rx_drv = 1'b1;
    logic        loop = 1'b0;
    logic        rx_line;
    logic [7:0]  resp;
    logic        resp_rdy;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    assign rx_line = loop ? tx_w : rx_drv;

    remote_comm #(.BAUD_DIV(BD)) dut (
        .clk      (clk),
        .rst      (rst),
        .cmd      (cmd),
        .snd_cmd  (snd_cmd),
        .cmd_snt  (cmd_snt),
        .TX       (tx_w),
        .RX       (rx_line),
        .resp     (resp),
        .resp_rdy (resp_rdy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Expected line level for frame bit idx (0 start, 1..8 data LSB first, 9 stop).
    function automatic logic exp_bit(input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        if (idx == 9) return 1'b1;
        return b[idx-1];
    endfunction

    task automatic drive_frame(input logic [7:0] b, input logic stop);
        rx_drv = 1'b0;
        repeat (BD) tick();
        for (int i = 0; i < 8; i++) begin
            rx_drv = b[i];
            repeat (BD) tick();
        end
        rx_drv = stop;
        repeat (BD) tick();
        rx_drv = 1'b1;
    endtask

    initial begin
        int rise;
        int lows;
        int rises;
        int nbytes;
        int ok;
        logic prev_rdy;
        logic prev_snt;
        logic [7:0] got [4];
        logic [7:0] ebyte;

        // ---------------- reset ----------------
        rst = 1'b1;
        repeat (2) tick();
        check("rst_tx", tx_w, 1);
        check("rst_cmd_snt", cmd_snt, 0);
        check("rst_resp_rdy", resp_rdy, 0);
        check("rst_resp", resp, 8'h00);
        rst = 1'b0;
        repeat (3) tick();

        // ---------------- send 0x43F2, check every bit mid-cell ----------------
        cmd = 16'h43F2;
        snd_cmd = 1'b1;
        tick();                     // acceptance edge = clock 0
        snd_cmd = 1'b0;
        cmd = 16'h0000;             // must not affect the latched command
        check("tx_start_after_accept", tx_w, 0);
        check("cmd_snt_cleared", cmd_snt, 0);
        rise = -1;
        for (int n = 1; n <= 400 && rise < 0; n++) begin
            tick();
            if ((n % BD) == (BD / 2) && n < 20 * BD) begin
                ebyte = ((n / BD) < 10) ? 8'h43 : 8'hF2;
                check($sformatf("tx_43F2_bit%0d", n / BD), tx_w, exp_bit(ebyte, (n / BD) % 10));
            end
            if (cmd_snt && rise < 0) rise = n;
        end
        check("cmd_snt_rise_window", (rise >= 20 * BD - 1 && rise <= 20 * BD + 1), 1);
        repeat (20) tick();
        check("cmd_snt_holds", cmd_snt, 1);
        check("tx_idle_after_cmd", tx_w, 1);

        // ---------------- loopback 0x5001 ----------------
        loop = 1'b1;
        cmd = 16'h5001;
        snd_cmd = 1'b1;
        tick();
        snd_cmd = 1'b0;
        ok = 0;
        for (int n = 0; n < 400 && !ok; n++) begin tick(); if (resp_rdy) ok = 1; end
        check("loop_rdy1_seen", ok, 1);
        check("loop_resp_50", resp, 8'h50);
        ok = 0;
        for (int n = 0; n < 400 && !ok; n++) begin tick(); if (!resp_rdy) ok = 1; end
        check("loop_rdy_clears", ok, 1);
        ok = 0;
        for (int n = 0; n < 400 && !ok; n++) begin tick(); if (resp_rdy) ok = 1; end
        check("loop_rdy2_seen", ok, 1);
        check("loop_resp_01", resp, 8'h01);
        ok = 0;
        for (int n = 0; n < 400 && !ok; n++) begin tick(); if (cmd_snt) ok = 1; end
        check("loop_cmd_snt", ok, 1);
        repeat (5) tick();
        loop = 1'b0;
        repeat (5) tick();

        // ---------------- direct RX: 0xA5 ack, then glitch ----------------
        drive_frame(8'hA5, 1'b1);
        repeat (10) tick();
        check("rx_a5_resp", resp, 8'hA5);
        check("rx_a5_rdy", resp_rdy, 1);
        rx_drv = 1'b0;
        repeat (5) tick();          // ~0.3 bit
        rx_drv = 1'b1;
        repeat (40) tick();
        check("glitch_resp", resp, 8'hA5);
        check("glitch_rdy", resp_rdy, 1);

        // ---------------- framing error ----------------
        // The valid start bit drops resp_rdy; the bad stop bit must not load or flag the byte.
        drive_frame(8'h3C, 1'b0);
        repeat (10) tick();
        check("frame_err_resp", resp, 8'hA5);
        check("frame_err_rdy", resp_rdy, 0);
        drive_frame(8'h3C, 1'b1);
        repeat (10) tick();
        check("recover_resp", resp, 8'h3C);
        check("recover_rdy", resp_rdy, 1);

        // ---------------- snd_cmd ignored mid-transmission ----------------
        loop = 1'b1;
        cmd = 16'hABCD;
        snd_cmd = 1'b1;
        tick();
        snd_cmd = 1'b0;
        prev_rdy = resp_rdy;
        prev_snt = cmd_snt;
        rises = 0;
        nbytes = 0;
        lows = 0;
        for (int n = 1; n <= 800; n++) begin
            if (n == 50 || n == 200) begin cmd = 16'h1234; snd_cmd = 1'b1; end
            else snd_cmd = 1'b0;
            tick();
            if (resp_rdy && !prev_rdy) begin
                if (nbytes < 4) got[nbytes] = resp;
                nbytes++;
            end
            if (cmd_snt && !prev_snt) rises++;
            prev_rdy = resp_rdy;
            prev_snt = cmd_snt;
            if (n > 20 * BD + 2 && !tx_w) lows++;
        end
        snd_cmd = 1'b0;
        check("ignore_nbytes", nbytes, 2);
        check("ignore_byte0", got[0], 8'hAB);
        check("ignore_byte1", got[1], 8'hCD);
        check("ignore_snt_rises", rises, 1);
        check("ignore_no_third_frame", lows, 0);
        loop = 1'b0;
        repeat (5) tick();

        // ---------------- reset mid-frame ----------------
        cmd = 16'h00FF;
        snd_cmd = 1'b1;
        tick();
        snd_cmd = 1'b0;
        repeat (20) tick();         // inside data bit 0 of 0x00
        check("midframe_tx_low", tx_w, 0);
        rst = 1'b1;
        tick();
        check("midrst_tx", tx_w, 1);
        check("midrst_cmd_snt", cmd_snt, 0);
        check("midrst_resp_rdy", resp_rdy, 0);
        check("midrst_resp", resp, 8'h00);
        rst = 1'b0;
        lows = 0;
        for (int n = 0; n < 400; n++) begin tick(); if (!tx_w) lows++; end
        check("abandoned_frame_tx_idle", lows, 0);
        check("abandoned_frame_no_snt", cmd_snt, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
